// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 mode constants and timing helpers shared by the VGA timing generator.
// Helpers are constant functions, evaluated at elaboration only.
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE    = 640;
    localparam int DEF_H_FP        = 16;
    localparam int DEF_H_SYNC      = 96;
    localparam int DEF_H_BP        = 48;
    localparam int DEF_V_ACTIVE    = 480;
    localparam int DEF_V_FP        = 10;
    localparam int DEF_V_SYNC      = 2;
    localparam int DEF_V_BP        = 33;
    localparam int DEF_SCALE_SHIFT = 1;
    localparam int DEF_WIN_Y_STA   = 150;
    localparam int DEF_WIN_Y_END   = 330;
    localparam int DEF_X_W         = 10;
    localparam int DEF_Y_W         = 9;
    localparam int DEF_FRAME_W     = 16;

    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int sync_sta(input int active, input int fp);
        return active + fp;
    endfunction

    function automatic int sync_end(input int active, input int fp, input int sync);
        return active + fp + sync;
    endfunction

    // Bits needed to hold 0..n-1, never less than 1.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Timing bundle from the VGA timing generator to the pixel pipeline.
// Master drives every field; consumers take the slave view.
interface vga_timing_gen_if #(
    parameter int X_W     = vga_timing_pkg::DEF_X_W,
    parameter int Y_W     = vga_timing_pkg::DEF_Y_W,
    parameter int FRAME_W = vga_timing_pkg::DEF_FRAME_W
);
    logic               o_hs;
    logic               o_vs;
    logic               o_blanking;
    logic               o_active;
    logic               o_line_start;
    logic               o_screenend;
    logic               o_animate;
    logic [X_W-1:0]     o_x;
    logic [Y_W-1:0]     o_y;
    logic [FRAME_W-1:0] o_frame;

    modport master (
        output o_hs, o_vs, o_blanking, o_active, o_line_start,
               o_screenend, o_animate, o_x, o_y, o_frame
    );

    modport slave (
        input  o_hs, o_vs, o_blanking, o_active, o_line_start,
               o_screenend, o_animate, o_x, o_y, o_frame
    );
endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis (active, FP, SYNC, BP); outputs are look-ahead values of the count after this edge,
// so the parent can register its decodes with one clock of latency. Steps only when i_step is high.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int  ACTIVE = DEF_H_ACTIVE,
    parameter int  FP     = DEF_H_FP,
    parameter int  SYNC   = DEF_H_SYNC,
    parameter int  BP     = DEF_H_BP,
    parameter bit  POL    = 1'b0,
    localparam int TOTAL  = axis_total(ACTIVE, FP, SYNC, BP),
    localparam int CW     = clog2(TOTAL)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_step,
    output logic [CW-1:0] o_count,
    output logic          o_wrap,
    output logic          o_sync,
    output logic          o_visible
);
    localparam int SS = sync_sta(ACTIVE, FP);
    localparam int SE = sync_end(ACTIVE, FP, SYNC);

    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic          at_last;
    logic          in_sync;

    assign at_last = (count == CW'(TOTAL - 1));
    assign o_wrap  = i_step && at_last;

    always_comb begin
        count_nxt = count;
        if (i_step) count_nxt = at_last ? '0 : count + 1'b1;
    end

    assign in_sync   = (count_nxt >= CW'(SS)) && (count_nxt < CW'(SE));
    assign o_count   = count_nxt;
    assign o_sync    = in_sync ? POL : ~POL;
    assign o_visible = (count_nxt < CW'(ACTIVE));

    always_ff @(posedge i_clk) begin
        if (i_rst) count <= '0;
        else       count <= count_nxt;
    end
endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing: sync, blanking, letterbox window, scaled x/y and frame strobes.
// Every output is a register, valid one clock after the pixel strobe; outputs hold between strobes.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int H_FP        = DEF_H_FP,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BP        = DEF_H_BP,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int V_FP        = DEF_V_FP,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_BP        = DEF_V_BP,
    parameter bit H_POL       = 1'b0,
    parameter bit V_POL       = 1'b0,
    parameter int SCALE_SHIFT = DEF_SCALE_SHIFT,
    parameter int WIN_Y_STA   = DEF_WIN_Y_STA,
    parameter int WIN_Y_END   = DEF_WIN_Y_END,
    parameter int X_W         = DEF_X_W,
    parameter int Y_W         = DEF_Y_W,
    parameter int FRAME_W     = DEF_FRAME_W
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_pix_stb,
    vga_timing_gen_if.master   bus
);
    localparam int HW       = clog2(axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP));
    localparam int VW       = clog2(axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP));
    localparam int Y_CLAMP  = (WIN_Y_END - WIN_Y_STA - 1) >> SCALE_SHIFT;
    localparam bit ACT_RST  = (WIN_Y_STA == 0);

    if (WIN_Y_STA >= WIN_Y_END || WIN_Y_END > V_ACTIVE ||
        H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_cfg
        $error("vga_timing_gen: invalid window or zero porch/sync width");
    end

    logic [HW-1:0]  h_nxt;
    logic           h_wrap, h_sync, h_vis;
    logic [VW-1:0]  v_nxt;
    logic           v_wrap, v_sync, v_vis;
    int             v_i;
    logic           in_win;
    logic [X_W-1:0] x_nxt;
    logic [Y_W-1:0] y_nxt;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(H_POL)
    ) u_h (
        .i_clk, .i_rst, .i_step(i_pix_stb),
        .o_count(h_nxt), .o_wrap(h_wrap), .o_sync(h_sync), .o_visible(h_vis)
    );

    // Lines advance on the horizontal wrap, not on the pixel strobe.
    vga_axis_counter #(
        .ACTIVE (V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(V_POL)
    ) u_v (
        .i_clk, .i_rst, .i_step(h_wrap),
        .o_count(v_nxt), .o_wrap(v_wrap), .o_sync(v_sync), .o_visible(v_vis)
    );

    assign v_i    = int'(v_nxt);
    assign in_win = (v_i >= WIN_Y_STA) && (v_i < WIN_Y_END);
    assign x_nxt  = X_W'(h_nxt >> SCALE_SHIFT);

    // Below the window y holds its last in-window value so renderers never see a jump.
    always_comb begin
        y_nxt = '0;
        if (v_i >= WIN_Y_END)      y_nxt = Y_W'(Y_CLAMP);
        else if (v_i >= WIN_Y_STA) y_nxt = Y_W'((v_i - WIN_Y_STA) >> SCALE_SHIFT);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bus.o_hs         <= ~H_POL;
            bus.o_vs         <= ~V_POL;
            bus.o_blanking   <= 1'b0;
            bus.o_active     <= ACT_RST;
            bus.o_line_start <= 1'b0;
            bus.o_screenend  <= 1'b0;
            bus.o_animate    <= 1'b0;
            bus.o_x          <= '0;
            bus.o_y          <= '0;
            bus.o_frame      <= '0;
        end else begin
            bus.o_hs         <= h_sync;
            bus.o_vs         <= v_sync;
            bus.o_blanking   <= ~(h_vis & v_vis);
            bus.o_active     <= h_vis & in_win;
            bus.o_line_start <= h_wrap;
            bus.o_screenend  <= h_wrap & v_wrap;
            bus.o_animate    <= h_wrap & (v_i == WIN_Y_END);
            bus.o_x          <= h_vis ? x_nxt : '0;
            bus.o_y          <= y_nxt;
            if (h_wrap & v_wrap) bus.o_frame <= bus.o_frame + 1'b1;
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three modes driven by one strobe, checked against a strobe-count model.
module tb_vga_timing_gen;

    typedef struct {
        int ha, hfp, hsw, hbp;
        int va, vfp, vsw, vbp;
        bit hpol, vpol;
        int sh, ws, we, xw, yw, fw;
    } cfg_t;

    typedef struct {
        bit hs, vs, blank, active, ls, se, an;
        int x, y, frame;
    } exp_t;

    logic clk, rst, stb;
    int   checks, errors;
    longint n;
    bit   fired;
    cfg_t c0, c1, c2;

    vga_timing_gen_if                                     b0 ();
    vga_timing_gen_if #(.X_W(4), .Y_W(2), .FRAME_W(2))    b1 ();
    vga_timing_gen_if #(.X_W(3), .Y_W(3), .FRAME_W(4))    b2 ();

    vga_timing_gen u_d0 (.i_clk(clk), .i_rst(rst), .i_pix_stb(stb), .bus(b0));

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .H_POL(1'b0), .V_POL(1'b0), .SCALE_SHIFT(1),
        .WIN_Y_STA(4), .WIN_Y_END(9), .X_W(4), .Y_W(2), .FRAME_W(2)
    ) u_d1 (.i_clk(clk), .i_rst(rst), .i_pix_stb(stb), .bus(b1));

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b1), .SCALE_SHIFT(0),
        .WIN_Y_STA(0), .WIN_Y_END(6), .X_W(3), .Y_W(3), .FRAME_W(4)
    ) u_d2 (.i_clk(clk), .i_rst(rst), .i_pix_stb(stb), .bus(b2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected outputs from the number of strobes since reset.
    function automatic exp_t model(input cfg_t c, input longint cnt, input bit f);
        exp_t   e;
        longint ht, vt, pos, h, v;
        ht = c.ha + c.hfp + c.hsw + c.hbp;
        vt = c.va + c.vfp + c.vsw + c.vbp;
        pos = cnt % (ht * vt);
        h = pos % ht;
        v = pos / ht;
        e.frame  = int'((cnt / (ht * vt)) % (longint'(1) << c.fw));
        e.hs     = (h >= c.ha + c.hfp && h < c.ha + c.hfp + c.hsw) ? c.hpol : !c.hpol;
        e.vs     = (v >= c.va + c.vfp && v < c.va + c.vfp + c.vsw) ? c.vpol : !c.vpol;
        e.blank  = (h >= c.ha) || (v >= c.va);
        e.active = (h < c.ha) && (v >= c.ws) && (v < c.we);
        e.x      = (h < c.ha) ? (int'(h >> c.sh) & ((1 << c.xw) - 1)) : 0;
        if (v < c.ws)      e.y = 0;
        else if (v < c.we) e.y = int'((v - c.ws) >> c.sh);
        else               e.y = (c.we - c.ws - 1) >> c.sh;
        e.y      = e.y & ((1 << c.yw) - 1);
        e.ls     = f && (h == 0);
        e.se     = f && (pos == 0);
        e.an     = f && (h == 0) && (v == c.we);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic check_dut(input string dn, input cfg_t c,
                             input logic hs, input logic vs, input logic bl, input logic ac,
                             input logic ls, input logic se, input logic an,
                             input logic [31:0] x, input logic [31:0] y, input logic [31:0] fr);
        exp_t e;
        e = model(c, n, fired);
        chk({dn, ".hs"},         32'(hs), 32'(e.hs));
        chk({dn, ".vs"},         32'(vs), 32'(e.vs));
        chk({dn, ".blanking"},   32'(bl), 32'(e.blank));
        chk({dn, ".active"},     32'(ac), 32'(e.active));
        chk({dn, ".line_start"}, 32'(ls), 32'(e.ls));
        chk({dn, ".screenend"},  32'(se), 32'(e.se));
        chk({dn, ".animate"},    32'(an), 32'(e.an));
        chk({dn, ".x"},          x, e.x);
        chk({dn, ".y"},          y, e.y);
        chk({dn, ".frame"},      fr, e.frame);
    endtask

    task automatic check_all();
        check_dut("d0", c0, b0.o_hs, b0.o_vs, b0.o_blanking, b0.o_active, b0.o_line_start,
                  b0.o_screenend, b0.o_animate, 32'(b0.o_x), 32'(b0.o_y), 32'(b0.o_frame));
        check_dut("d1", c1, b1.o_hs, b1.o_vs, b1.o_blanking, b1.o_active, b1.o_line_start,
                  b1.o_screenend, b1.o_animate, 32'(b1.o_x), 32'(b1.o_y), 32'(b1.o_frame));
        check_dut("d2", c2, b2.o_hs, b2.o_vs, b2.o_blanking, b2.o_active, b2.o_line_start,
                  b2.o_screenend, b2.o_animate, 32'(b2.o_x), 32'(b2.o_y), 32'(b2.o_frame));
    endtask

    // One clock: drive inputs, advance the model on the edge, compare 1 time unit later.
    task automatic step(input bit s, input bit r);
        stb = s;
        rst = r;
        @(posedge clk);
        if (r) begin
            n = 0;
            fired = 1'b0;
        end else begin
            fired = s;
            if (s) n++;
        end
        #1;
        check_all();
    endtask

    initial begin
        int hs_low, hs_first, blank_cnt, ls_cnt, x639;
        int se_cnt, an_cnt, vs_low, d2_hs_hi;
        bit s, r;

        checks = 0;
        errors = 0;
        n = 0;
        fired = 1'b0;
        stb = 1'b0;
        rst = 1'b1;
        c0 = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 1, 150, 330, 10, 9, 16};
        c1 = '{16, 2, 3, 3, 12, 1, 2, 2, 1'b0, 1'b0, 1, 4, 9, 4, 2, 2};
        c2 = '{8, 1, 2, 1, 6, 1, 1, 1, 1'b1, 1'b1, 0, 0, 6, 3, 3, 4};

        // Reset held three clocks while the strobe toggles.
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        chk("rst.d0_hs", 32'(b0.o_hs), 32'd1);
        chk("rst.d0_vs", 32'(b0.o_vs), 32'd1);
        chk("rst.d0_active", 32'(b0.o_active), 32'd0);
        chk("rst.d0_frame", 32'(b0.o_frame), 32'd0);
        chk("rst.d2_active", 32'(b2.o_active), 32'd1);
        chk("rst.d2_hs", 32'(b2.o_hs), 32'd0);
        step(1'b1, 1'b0);
        chk("first_stb.d2_x", 32'(b2.o_x), 32'd1);

        // One full default line, strobe every fourth clock.
        step(1'b0, 1'b1);
        hs_low = 0; hs_first = -1; blank_cnt = 0; ls_cnt = 0; x639 = -1;
        for (int i = 1; i <= 800; i++) begin
            step(1'b1, 1'b0);
            if (b0.o_hs === 1'b0) begin
                if (hs_first < 0) hs_first = i;
                hs_low++;
            end
            if (b0.o_blanking === 1'b1) blank_cnt++;
            if (b0.o_line_start === 1'b1) ls_cnt++;
            if (i == 639) x639 = int'(b0.o_x);
            for (int k = 0; k < 3; k++) step(1'b0, 1'b0);
        end
        chk("line.hs_low_strobes", hs_low, 96);
        chk("line.hs_first_h", hs_first, 656);
        chk("line.blank_strobes", blank_cnt, 160);
        chk("line.line_start_cnt", ls_cnt, 1);
        chk("line.x_at_639", x639, 319);

        // Four small frames back to back: the 2-bit frame counter wraps to 0.
        step(1'b0, 1'b1);
        se_cnt = 0; an_cnt = 0; vs_low = 0; d2_hs_hi = 0;
        for (int i = 1; i <= 4 * 408; i++) begin
            step(1'b1, 1'b0);
            if (b1.o_screenend === 1'b1) se_cnt++;
            if (b1.o_animate === 1'b1) an_cnt++;
            if (b1.o_vs === 1'b0) vs_low++;
            if (i <= 12 && b2.o_hs === 1'b1) d2_hs_hi++;
            if (i == 7) chk("alt.x_max", 32'(b2.o_x), 32'd7);
            if (i == 60) begin
                chk("alt.y_last_line", 32'(b2.o_y), 32'd5);
                chk("alt.active_last_line", 32'(b2.o_active), 32'd1);
            end
        end
        chk("frame.screenend_cnt", se_cnt, 4);
        chk("frame.animate_cnt", an_cnt, 4);
        chk("frame.vs_low_strobes", vs_low, 192);
        chk("frame.wrapped", 32'(b1.o_frame), 32'd0);
        chk("alt.hs_high_strobes", d2_hs_hi, 2);

        // Random strobes with rare resets.
        for (int i = 0; i < 2500; i++) begin
            s = ($urandom_range(0, 1) == 1);
            r = ($urandom_range(0, 799) == 0);
            step(s, r);
        end

        // Strobe gap: everything holds (the model keeps n fixed).
        for (int i = 0; i < 50; i++) step(1'b0, 1'b0);

        // Advance mid-frame, then reset together with a strobe.
        for (int i = 0; i < 150; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        chk("midrst.d1_screenend", 32'(b1.o_screenend), 32'd0);
        chk("midrst.d1_frame", 32'(b1.o_frame), 32'd0);
        chk("midrst.d0_x", 32'(b0.o_x), 32'd0);

        for (int i = 0; i < 1500; i++) begin
            s = ($urandom_range(0, 3) != 0);
            step(s, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
